// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address generation unit: default
// transform size, derived sizes and the sequencer state encoding.
package fft_pkg;

    localparam int N_LOG2_DEF = 5;
    localparam int N_DEF      = 1 << N_LOG2_DEF;
    localparam int HALF_DEF   = N_DEF / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Width of the level counter. It must hold 0..n_log2-1.
    function automatic int lvl_width(input int n_log2);
        return (n_log2 > 1) ? $clog2(n_log2) : 1;
    endfunction

endpackage

// File: rtl/fft_agu_if.sv
// Control/address bundle between the address generator (master) and the
// memory banks, twiddle ROM and butterfly datapath (slave).
interface fft_agu_if
    import fft_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF
) ();

    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [N_LOG2-1:0] rd_adr_a;
    logic [N_LOG2-1:0] rd_adr_b;
    logic [N_LOG2-2:0] tw_adr;
    logic              rd_bank;
    logic              wr_en;
    logic [N_LOG2-1:0] wr_adr_a;
    logic [N_LOG2-1:0] wr_adr_b;
    logic              wr_bank;

    modport master (
        input  start,
        output busy, done,
        output rd_en, rd_adr_a, rd_adr_b, tw_adr, rd_bank,
        output wr_en, wr_adr_a, wr_adr_b, wr_bank
    );

    modport slave (
        output start,
        input  busy, done,
        input  rd_en, rd_adr_a, rd_adr_b, tw_adr, rd_bank,
        input  wr_en, wr_adr_a, wr_adr_b, wr_bank
    );

endinterface

// File: rtl/fft_adr_rotl.sv
// Rotate a W-bit butterfly index left by amt places. This turns the
// natural pair index into the stride pattern of the current level.
module fft_adr_rotl #(
    parameter int W     = 5,
    parameter int AMT_W = 3
) (
    input  logic [W-1:0]     din,
    input  logic [AMT_W-1:0] amt,
    output logic [W-1:0]     dout
);

    // When amt is 0, the right shift by W is all zeros. The result is then din.
    assign dout = (din << amt) | (din >> (W - int'(amt)));

endmodule

// File: rtl/fft_agu.sv
// Address generation unit for an in-place, ping-pong radix-2 FFT. It
// runs N_LOG2 levels of N/2 butterflies. Each level reads one bank and
// writes the other. Write addresses trail the reads by one cycle, which
// covers the synchronous memory/ROM read.
module fft_agu
    import fft_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF
) (
    input  logic      clk,
    input  logic      reset,
    fft_agu_if.master bus
);

    localparam int TW_W  = N_LOG2 - 1;
    localparam int LVL_W = lvl_width(N_LOG2);

    localparam logic [TW_W-1:0]  J_LAST = '1;
    localparam logic [LVL_W-1:0] I_LAST = LVL_W'(N_LOG2 - 1);

    state_e            state_q, state_d;
    logic [LVL_W-1:0]  i_q, i_d;
    logic [TW_W-1:0]   j_q, j_d;

    logic              rd_en;
    logic              busy;
    logic              done;
    logic [N_LOG2-1:0] rot_a, rot_b;
    logic [N_LOG2-1:0] rd_adr_a, rd_adr_b;
    logic [LVL_W-1:0]  tw_shamt;
    logic [TW_W-1:0]   tw_mask;
    logic [TW_W-1:0]   tw_adr;
    logic              rd_bank;

    logic              wr_en_q, wr_en_d;
    logic [N_LOG2-1:0] wr_adr_a_q, wr_adr_a_d;
    logic [N_LOG2-1:0] wr_adr_b_q, wr_adr_b_d;
    logic              wr_bank_q, wr_bank_d;

    // Operand pair (2j, 2j+1) is rotated by the level number.
    fft_adr_rotl #(.W(N_LOG2), .AMT_W(LVL_W)) u_rotl_a (
        .din  ({j_q, 1'b0}),
        .amt  (i_q),
        .dout (rot_a)
    );

    fft_adr_rotl #(.W(N_LOG2), .AMT_W(LVL_W)) u_rotl_b (
        .din  ({j_q, 1'b1}),
        .amt  (i_q),
        .dout (rot_b)
    );

    // Sequencer: next state, level/butterfly counters and status strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rd_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (j_q == J_LAST) begin
                    j_d = '0;
                    if (i_q == I_LAST) begin
                        i_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-side addresses. Twiddle stride masking. Outputs are zero when not reading.
    always_comb begin
        tw_shamt   = LVL_W'(TW_W) - i_q;
        tw_mask    = ~((TW_W'(1) << tw_shamt) - TW_W'(1));
        rd_adr_a   = rd_en ? rot_a : '0;
        rd_adr_b   = rd_en ? rot_b : '0;
        tw_adr     = rd_en ? (j_q & tw_mask) : '0;
        rd_bank    = rd_en & i_q[0];
        wr_en_d    = rd_en;
        wr_adr_a_d = rd_adr_a;
        wr_adr_b_d = rd_adr_b;
        wr_bank_d  = rd_en & ~i_q[0];
    end

    // State, counters and the one-cycle write pipeline. Reset is synchronous.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so all flops update together from pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            wr_en_q    <= 1'b0;
            wr_adr_a_q <= '0;
            wr_adr_b_q <= '0;
            wr_bank_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            wr_en_q    <= wr_en_d;
            wr_adr_a_q <= wr_adr_a_d;
            wr_adr_b_q <= wr_adr_b_d;
            wr_bank_q  <= wr_bank_d;
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.rd_en    = rd_en;
    assign bus.rd_adr_a = rd_adr_a;
    assign bus.rd_adr_b = rd_adr_b;
    assign bus.tw_adr   = tw_adr;
    assign bus.rd_bank  = rd_bank;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_adr_a = wr_adr_a_q;
    assign bus.wr_adr_b = wr_adr_b_q;
    assign bus.wr_bank  = wr_bank_q;

endmodule
